// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter with optional prescaler, clamped parallel load,
// wrap or saturate at the bounds, a one-cycle bound pulse and a sticky overflow flag.
module counter_mod_updown #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 10,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse,
    output logic             overflow
);

    // WIDTH+1 bits so MODULUS == 2**WIDTH is representable
    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX   = (WIDTH+1)'(MODULUS - 1);

    logic             step;
    logic [WIDTH:0]   count_ext;
    logic             bound_hit;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] load_clamped;

    generate
        if (PRESCALE == 1) begin : g_no_pre
            assign step = en;
        end else begin : g_pre
            localparam int unsigned PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] pre;

            // Load also restarts the prescale period
            always_ff @(posedge clk) begin
                if (reset || clear || load) begin
                    pre <= '0;
                end else if (en) begin
                    pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                end
            end

            assign step = en && (pre == PRE_LAST);
        end
    endgenerate

    always_comb begin
        count_ext    = {1'b0, count};
        at_max       = (count_ext == MAX);
        at_min       = (count_ext == '0);
        bound_hit    = up_dn ? at_max : at_min;
        wrap_val     = up_dn ? '0 : MAX[WIDTH-1:0];
        next_val     = up_dn ? WIDTH'(count_ext + 1'b1) : WIDTH'(count_ext - 1'b1);
        load_clamped = ({1'b0, load_val} >= LIMIT) ? MAX[WIDTH-1:0] : load_val;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else if (load) begin
            count      <= load_clamped;
            wrap_pulse <= 1'b0;
        end else if (step) begin
            if (bound_hit) begin
                wrap_pulse <= 1'b1;
                overflow   <= 1'b1;
                if (SATURATE == 0) begin
                    count <= wrap_val;
                end
            end else begin
                count      <= next_val;
                wrap_pulse <= 1'b0;
            end
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

endmodule
